uart_rx_os: RTL
===============

// Module: uart_rx_os
// PURPOSE
//  Next-generation UART receiver: 16x-oversampled serial input, 3-sample majority vote per bit.
//  Runtime-programmable divisor, 5..8 data bits, none/even/odd parity, 1/2 stop bits.
//  Per-word parity/framing/break status; valid/ready output with overrun detection.
//  Sits between the pad synchroniser-free rx pin and the peripheral register/FIFO layer.
// PARAMETERS
//  DATA_WIDTH   8   max data bits; o_rx_data width
//  OS_RATE      16  oversample ticks per bit; even, >=8
//  DIV_WIDTH    16  width of i_cfg_div
//  SYNC_STAGES  2   flops on i_rx_serial before any use
// PORTS
//  clk           in   1           single clock
//  rst_n         in   1           asynchronous, active-low reset
//  i_rx_en       in   1           receiver enable; 0 aborts any frame
//  i_rx_serial   in   1           async serial line, idle high
//  i_cfg_div     in   DIV_WIDTH   clk cycles per oversample tick, minus 1
//  i_cfg_bits    in   2           00/01/10/11 = 5/6/7/8 data bits
//  i_cfg_parity  in   2           00 none, 01 even, 10 odd, 11 none
//  i_cfg_stop2   in   1           1 = two stop bits
//  o_rx_data     out  DATA_WIDTH  received word, LSB-first, right-aligned, upper bits 0
//  o_rx_valid    out  1           word held; stays high until i_rx_ready
//  i_rx_ready    in   1           consumer accepts word when valid&ready
//  o_parity_err  out  1           status of held word
//  o_frame_err   out  1           status of held word: a stop bit sampled 0
//  o_break       out  1           status of held word: all data, parity, stop bits 0
//  o_overrun     out  1           sticky: word dropped while valid held
//  o_rx_busy     out  1           FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, tick counter 0, arm flag 0.
//  Tick: counter 0..i_cfg_div, one-cycle tick at wrap; div=0 -> tick every clk.
//   Counter frozen at 0 while IDLE; restarts on start detection.
//  Line = synchronised rx (SYNC_STAGES latency).
//   Arm flag set when line is 1 while IDLE; cleared on start.
//  IDLE->START: i_rx_en & armed & line==0. Latch cfg; later cfg changes ignored until next IDLE.
//  Per bit: os_cnt 0..OS_RATE-1 on ticks.
//   Samples at OS_RATE/2-1, OS_RATE/2, OS_RATE/2+1; bit = majority of the three.
//  START: vote 0 -> DATA at bit end; vote 1 -> false start, back to IDLE, nothing reported.
//  DATA: shift bits LSB-first, N=5..8 from cfg, then PARITY if enabled else STOP.
//  PARITY: even -> XOR(data,parity)==0 expected; odd -> ==1; mismatch sets parity_err.
//  STOP: each stop bit voted; any 0 -> frame_err.
//   Last stop bit: complete at its vote (mid-bit), not bit end; FSM -> IDLE.
//  Completion latency: o_rx_valid high on the clk after the last stop vote tick.
//  Completion with valid=0, or valid&ready in same cycle: load data + 3 status bits, valid=1.
//  Completion with valid=1 & ready=0: new word dropped, held word kept, o_overrun=1.
//  Handshake valid&ready with no completion: valid=0, o_overrun=0; status bits keep value.
//  Break: frame_err also 1; arm flag stays clear until line returns high.
//  i_rx_en=0 mid-frame: abort to IDLE next clk; output register untouched.
//  Async reset mid-frame: immediate IDLE, all outputs 0.
// STRUCTURE
//  uart_pkg: state_t {IDLE,START,DATA,PARITY,STOP}, parity_e {PAR_NONE,PAR_EVEN,PAR_ODD}.
//  uart_pkg also holds the bits-code-to-count function.
//  Sub-module uart_baud_tick: divisor counter, enable/restart inputs, tick output.
//  Synchroniser, FSM, vote, output register stay in uart_rx_os.
// TESTING (div=3, OS_RATE=16 -> 64 clk/bit)
//  8N1 0xA5, ready=0 -> data=0xA5, valid held, no err flags; ready pulse -> valid=0 next clk.
//  7E1 0x55 sent with parity bit 1 -> data=0x55, parity_err=1; 6O2 0x2A, correct parity -> no errs.
//  Start low 2 ticks only -> busy pulses, returns IDLE, valid stays 0.
//  Single-tick 1-glitch at mid of data bit 3 of 0x00 -> data=0x00; majority filters glitch.
//  Line low 12 bit times, 8N1 -> data=0x00, frame_err=1, break=1; no new start until line high.
//  Two 0x11/0x22 frames, ready=0 -> data=0x11, overrun=1; then ready -> valid=0, overrun=0.
//  i_rx_en=0, and separately rst_n=0, during data bit 4 -> busy=0, no valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART receiver.
//   state_t       : receiver FSM states
//   parity_e      : decoded parity mode
//   bits_count()  : 2-bit data-length code -> number of data bits (5..8)
//   parity_decode(): 2-bit parity code -> parity_e
package uart_pkg;

    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    function automatic logic [BIT_CNT_W-1:0] bits_count(input logic [1:0] code);
        return BIT_CNT_W'(5) + BIT_CNT_W'(code);
    endfunction

    function automatic parity_e parity_decode(input logic [1:0] code);
        case (code)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..div and pulses tick_c at the wrap.
//   clk, rst_n : clock, async active-low reset
//   en         : counting enabled; counter held at 0 when low
//   restart    : force counter back to 0 (start of a new frame)
//   div        : clk cycles per tick minus 1 (0 -> tick every enabled clk)
//   tick_c     : combinational one-cycle tick
module uart_baud_tick #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick_c
);

    logic [DIV_WIDTH-1:0] cnt_q;

    // Divisor counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en || restart) begin
            cnt_q <= '0;
        end else if (cnt_q == div) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
        end
    end

    assign tick_c = en && !restart && (cnt_q == div);

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampled UART receiver with 3-sample majority vote per bit.
//   clk, rst_n    : clock, async active-low reset
//   i_rx_en       : receiver enable; low aborts any frame in progress
//   i_rx_serial   : asynchronous serial line, idle high
//   i_cfg_div     : clk cycles per oversample tick minus 1
//   i_cfg_bits    : 5/6/7/8 data bits, i_cfg_parity: none/even/odd, i_cfg_stop2: two stop bits
//   o_rx_data     : received word, right-aligned, upper bits zero
//   o_rx_valid    : word held until i_rx_ready
//   o_parity_err, o_frame_err, o_break : status of the held word
//   o_overrun     : sticky, a word was dropped while one was held
//   o_rx_busy     : FSM not idle
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned OS_RATE     = 16,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rx_en,
    input  logic                  i_rx_serial,
    input  logic [DIV_WIDTH-1:0]  i_cfg_div,
    input  logic [1:0]            i_cfg_bits,
    input  logic [1:0]            i_cfg_parity,
    input  logic                  i_cfg_stop2,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ready,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_break,
    output logic                  o_overrun,
    output logic                  o_rx_busy
);

    localparam int unsigned OS_W = $clog2(OS_RATE);
    localparam logic [OS_W-1:0] POS_A    = OS_W'(OS_RATE / 2 - 1);
    localparam logic [OS_W-1:0] POS_B    = OS_W'(OS_RATE / 2);
    localparam logic [OS_W-1:0] POS_C    = OS_W'(OS_RATE / 2 + 1);
    localparam logic [OS_W-1:0] POS_LAST = OS_W'(OS_RATE - 1);

    // Input synchroniser
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx_serial};
        end
    end

    assign line = sync_q[SYNC_STAGES-1];

    state_t                 state_q, state_nxt;
    logic [OS_W-1:0]        os_cnt_q, os_cnt_nxt;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_nxt;
    logic [1:0]             smp_q, smp_nxt;
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_nxt;
    logic                   par_acc_q, par_acc_nxt;
    logic                   fe_acc_q, fe_acc_nxt;
    logic                   brk_acc_q, brk_acc_nxt;
    logic                   stop_cnt_q, stop_cnt_nxt;
    logic                   armed_q, armed_nxt;
    logic [BIT_CNT_W-1:0]   nbits_q, nbits_nxt;
    parity_e                par_mode_q, par_mode_nxt;
    logic                   stop2_q, stop2_nxt;
    logic [DIV_WIDTH-1:0]   div_q, div_nxt;

    logic start_c;
    logic tick_c;
    logic maj_c;
    logic complete_c;
    logic par_err_c;
    logic fe_fin_c;
    logic brk_fin_c;

    assign start_c = (state_q == IDLE) && i_rx_en && armed_q && !line;

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state_q != IDLE),
        .restart (start_c),
        .div     (div_q),
        .tick_c  (tick_c)
    );

    // FSM and frame datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            smp_q      <= '0;
            shreg_q    <= '0;
            par_acc_q  <= 1'b0;
            fe_acc_q   <= 1'b0;
            brk_acc_q  <= 1'b0;
            stop_cnt_q <= 1'b0;
            armed_q    <= 1'b0;
            nbits_q    <= '0;
            par_mode_q <= PAR_NONE;
            stop2_q    <= 1'b0;
            div_q      <= '0;
        end else begin
            state_q    <= state_nxt;
            os_cnt_q   <= os_cnt_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            smp_q      <= smp_nxt;
            shreg_q    <= shreg_nxt;
            par_acc_q  <= par_acc_nxt;
            fe_acc_q   <= fe_acc_nxt;
            brk_acc_q  <= brk_acc_nxt;
            stop_cnt_q <= stop_cnt_nxt;
            armed_q    <= armed_nxt;
            nbits_q    <= nbits_nxt;
            par_mode_q <= par_mode_nxt;
            stop2_q    <= stop2_nxt;
            div_q      <= div_nxt;
        end
    end

    // Next-state, sampling and vote logic
    always_comb begin
        state_nxt    = state_q;
        os_cnt_nxt   = os_cnt_q;
        bit_cnt_nxt  = bit_cnt_q;
        smp_nxt      = smp_q;
        shreg_nxt    = shreg_q;
        par_acc_nxt  = par_acc_q;
        fe_acc_nxt   = fe_acc_q;
        brk_acc_nxt  = brk_acc_q;
        stop_cnt_nxt = stop_cnt_q;
        armed_nxt    = armed_q;
        nbits_nxt    = nbits_q;
        par_mode_nxt = par_mode_q;
        stop2_nxt    = stop2_q;
        div_nxt      = div_q;
        complete_c   = 1'b0;

        // Third sample is taken live; the first two were stored on earlier ticks.
        maj_c = (smp_q[0] & smp_q[1]) | (smp_q[0] & line) | (smp_q[1] & line);

        // Final status includes the last stop bit's vote in this same cycle.
        fe_fin_c  = fe_acc_q | ~maj_c;
        brk_fin_c = brk_acc_q & ~maj_c;
        case (par_mode_q)
            PAR_EVEN: par_err_c = par_acc_q;
            PAR_ODD:  par_err_c = ~par_acc_q;
            default:  par_err_c = 1'b0;
        endcase

        if (state_q == IDLE) begin
            if (line) begin
                armed_nxt = 1'b1;
            end
            if (start_c) begin
                state_nxt    = START;
                armed_nxt    = 1'b0;
                os_cnt_nxt   = '0;
                bit_cnt_nxt  = '0;
                smp_nxt      = '0;
                shreg_nxt    = '0;
                par_acc_nxt  = 1'b0;
                fe_acc_nxt   = 1'b0;
                brk_acc_nxt  = 1'b1;
                stop_cnt_nxt = 1'b0;
                nbits_nxt    = bits_count(i_cfg_bits);
                par_mode_nxt = parity_decode(i_cfg_parity);
                stop2_nxt    = i_cfg_stop2;
                div_nxt      = i_cfg_div;
            end
        end else if (!i_rx_en) begin
            state_nxt = IDLE;
        end else if (tick_c) begin
            os_cnt_nxt = (os_cnt_q == POS_LAST) ? '0 : os_cnt_q + OS_W'(1);

            if (os_cnt_q == POS_A) begin
                smp_nxt[0] = line;
            end
            if (os_cnt_q == POS_B) begin
                smp_nxt[1] = line;
            end

            // Mid-bit vote
            if (os_cnt_q == POS_C) begin
                case (state_q)
                    START: begin
                        if (maj_c) begin
                            state_nxt = IDLE;
                        end
                    end
                    DATA: begin
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            if (bit_cnt_q == BIT_CNT_W'(i)) begin
                                shreg_nxt[i] = maj_c;
                            end
                        end
                        par_acc_nxt = par_acc_q ^ maj_c;
                        brk_acc_nxt = brk_acc_q & ~maj_c;
                    end
                    PARITY: begin
                        par_acc_nxt = par_acc_q ^ maj_c;
                        brk_acc_nxt = brk_acc_q & ~maj_c;
                    end
                    STOP: begin
                        fe_acc_nxt  = fe_fin_c;
                        brk_acc_nxt = brk_fin_c;
                        if (stop_cnt_q == stop2_q) begin
                            complete_c = 1'b1;
                            state_nxt  = IDLE;
                        end
                    end
                    default: ;
                endcase
            end

            // Bit end
            if (os_cnt_q == POS_LAST) begin
                case (state_q)
                    START: state_nxt = DATA;
                    DATA: begin
                        if (bit_cnt_q == nbits_q - BIT_CNT_W'(1)) begin
                            state_nxt = (par_mode_q == PAR_NONE) ? STOP : PARITY;
                        end else begin
                            bit_cnt_nxt = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                    PARITY: state_nxt = STOP;
                    STOP:   stop_cnt_nxt = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Output holding register and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
            o_rx_busy    <= 1'b0;
        end else begin
            o_rx_busy <= (state_nxt != IDLE);
            if (complete_c && (!o_rx_valid || i_rx_ready)) begin
                o_rx_data    <= shreg_q;
                o_parity_err <= par_err_c;
                o_frame_err  <= fe_fin_c;
                o_break      <= brk_fin_c;
                o_rx_valid   <= 1'b1;
            end else if (complete_c) begin
                o_overrun <= 1'b1;
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
                o_overrun  <= 1'b0;
            end
        end
    end

endmodule
